// File: rtl/eq_delay_checker_if.sv
// -----------------------------------------------------------------------------
// eq_delay_checker_if
//   Bundles the compare-side signals of eq_delay_checker. The harness drives
//   the reference/DUT samples through the master modport. The checker
//   consumes them and returns its verdicts through the slave modport.
//
//   Signals (harness -> checker):
//     chk_en     global compare enable
//     ref_valid  per-channel reference valid, CHANNELS bits
//     ref_data   reference samples, channel i at [i*WIDTH +: WIDTH]
//     dut_data   DUT samples, same packing as ref_data
//     cmp_mask   per-bit compare mask shared by all channels (1 = compared)
//   Signals (checker -> harness):
//     mismatch, prop                    combinational verdicts
//     err_sticky, err_count,
//     first_err_ch, first_err_cyc,
//     primed                            registered diagnostics
// -----------------------------------------------------------------------------
interface eq_delay_checker_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 1,
    parameter int COUNT_W  = 8
);
    logic                         chk_en;
    logic [CHANNELS-1:0]          ref_valid;
    logic [CHANNELS*WIDTH-1:0]    ref_data;
    logic [CHANNELS*WIDTH-1:0]    dut_data;
    logic [WIDTH-1:0]             cmp_mask;

    logic [CHANNELS-1:0]          mismatch;
    logic                         prop;
    logic                         err_sticky;
    logic [COUNT_W-1:0]           err_count;
    logic [2:0]                   first_err_ch;
    logic [COUNT_W-1:0]           first_err_cyc;
    logic                         primed;

    modport master (
        output chk_en, ref_valid, ref_data, dut_data, cmp_mask,
        input  mismatch, prop, err_sticky, err_count,
               first_err_ch, first_err_cyc, primed
    );

    modport slave (
        input  chk_en, ref_valid, ref_data, dut_data, cmp_mask,
        output mismatch, prop, err_sticky, err_count,
               first_err_ch, first_err_cyc, primed
    );
endinterface

// File: rtl/eq_delay_checker.sv
// -----------------------------------------------------------------------------
// eq_delay_checker
//   Latency-aligned equivalence checker. Each channel's reference sample is
//   pushed through a DELAY-deep {valid, data} delay line. The oldest stage
//   (the tap) is compared against the live DUT sample under a per-bit mask.
//   The combinational verdicts (mismatch, prop) are intended for direct use
//   in an assert property. The registered diagnostics record the error
//   history since reset.
//
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high; flushes the delay line and diagnostics
//     bus    eq_delay_checker_if.slave (see interface header for signals)
//
//   MODE=0 compares on every cycle against a zero-initialised delay line, so
//   the DUT must hold 0 during warm-up. MODE=1 compares only when the tap's
//   valid bit is set.
// -----------------------------------------------------------------------------
module eq_delay_checker #(
    parameter int WIDTH    = 8,
    parameter int DELAY    = 3,
    parameter int CHANNELS = 1,
    parameter int MODE     = 1,
    parameter int COUNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    eq_delay_checker_if.slave bus
);

    localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};
    localparam logic [31:0]        DELAY_U = 32'(DELAY);

    // Reject illegal configurations at elaboration time.
    generate
        if (DELAY < 1 || DELAY > 16) begin : g_bad_delay
            $error("eq_delay_checker: DELAY must lie in 1..16");
        end
        if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
            $error("eq_delay_checker: CHANNELS must lie in 1..8");
        end
    endgenerate

    // Lowest set index of the mismatch vector. The scan runs from the top
    // down, so the last hit wins and the lowest channel takes priority.
    function automatic logic [2:0] lowest_index(input logic [CHANNELS-1:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // ------------------------------------------------------------------
    // Delay line state
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]    stg_data_q  [CHANNELS][DELAY];
    logic [WIDTH-1:0]    stg_data_d  [CHANNELS][DELAY];
    logic [CHANNELS-1:0] stg_valid_q [DELAY];
    logic [CHANNELS-1:0] stg_valid_d [DELAY];

    // ------------------------------------------------------------------
    // Diagnostic state
    // ------------------------------------------------------------------
    logic [COUNT_W-1:0]  cyc_q,           cyc_d;
    logic [COUNT_W-1:0]  err_count_q,     err_count_d;
    logic [COUNT_W-1:0]  first_err_cyc_q, first_err_cyc_d;
    logic [2:0]          first_err_ch_q,  first_err_ch_d;
    logic                err_sticky_q,    err_sticky_d;
    logic                primed_q,        primed_d;

    logic [CHANNELS-1:0] mismatch_s;
    logic                any_mm_s;

    // Next state of the delay line: stage 0 takes the live reference and
    // every later stage takes its predecessor.
    always_comb begin
        stg_valid_d[0] = bus.ref_valid;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            stg_data_d[ch][0] = bus.ref_data[ch*WIDTH +: WIDTH];
        end
        for (int s = 1; s < DELAY; s++) begin
            stg_valid_d[s] = stg_valid_q[s-1];
            for (int ch = 0; ch < CHANNELS; ch++) begin
                stg_data_d[ch][s] = stg_data_q[ch][s-1];
            end
        end
    end

    // Per-channel compare of the aligned tap against the live DUT sample.
    // The compare is gated by reset, the global enable and (MODE=1) the
    // tap's valid bit.
    always_comb begin
        logic [WIDTH-1:0] diff_v;
        logic             qual_v;
        mismatch_s = {CHANNELS{1'b0}};
        diff_v     = {WIDTH{1'b0}};
        qual_v     = 1'b0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            diff_v = (stg_data_q[ch][DELAY-1] ^ bus.dut_data[ch*WIDTH +: WIDTH])
                     & bus.cmp_mask;
            if (MODE == 0) begin
                qual_v = 1'b1;
            end else begin
                qual_v = stg_valid_q[DELAY-1][ch];
            end
            if (!reset && bus.chk_en && qual_v && (|diff_v)) begin
                mismatch_s[ch] = 1'b1;
            end else begin
                mismatch_s[ch] = 1'b0;
            end
        end
    end

    // Next state of the cycle stamp, the error counter and the first-failure
    // capture.
    always_comb begin
        any_mm_s        = |mismatch_s;
        cyc_d           = cyc_q;
        err_count_d     = err_count_q;
        err_sticky_d    = err_sticky_q;
        first_err_ch_d  = first_err_ch_q;
        first_err_cyc_d = first_err_cyc_q;
        primed_d        = primed_q;

        if (cyc_q == CNT_MAX) begin
            cyc_d = cyc_q;
        end else begin
            cyc_d = cyc_q + COUNT_W'(1);
        end

        // primed latches once the stamp has counted DELAY clocks.
        if (32'(cyc_d) == DELAY_U) begin
            primed_d = 1'b1;
        end else begin
            primed_d = primed_q;
        end

        if (any_mm_s && (err_count_q != CNT_MAX)) begin
            err_count_d = err_count_q + COUNT_W'(1);
        end else begin
            err_count_d = err_count_q;
        end

        // Only the first failing cycle is captured. The stamp is the value
        // held before this clock's increment.
        if (any_mm_s && !err_sticky_q) begin
            err_sticky_d    = 1'b1;
            first_err_ch_d  = lowest_index(mismatch_s);
            first_err_cyc_d = cyc_q;
        end else begin
            err_sticky_d    = err_sticky_q;
            first_err_ch_d  = first_err_ch_q;
            first_err_cyc_d = first_err_cyc_q;
        end
    end

    // Delay line registers. Reset flushes every stage, so no pre-reset
    // sample can reach the tap.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < DELAY; s++) begin
                stg_valid_q[s] <= {CHANNELS{1'b0}};
                for (int ch = 0; ch < CHANNELS; ch++) begin
                    stg_data_q[ch][s] <= {WIDTH{1'b0}};
                end
            end
        end else begin
            for (int s = 0; s < DELAY; s++) begin
                stg_valid_q[s] <= stg_valid_d[s];
                for (int ch = 0; ch < CHANNELS; ch++) begin
                    stg_data_q[ch][s] <= stg_data_d[ch][s];
                end
            end
        end
    end

    // Diagnostic registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q           <= {COUNT_W{1'b0}};
            err_count_q     <= {COUNT_W{1'b0}};
            first_err_cyc_q <= {COUNT_W{1'b0}};
            first_err_ch_q  <= 3'd0;
            err_sticky_q    <= 1'b0;
            primed_q        <= 1'b0;
        end else begin
            cyc_q           <= cyc_d;
            err_count_q     <= err_count_d;
            first_err_cyc_q <= first_err_cyc_d;
            first_err_ch_q  <= first_err_ch_d;
            err_sticky_q    <= err_sticky_d;
            primed_q        <= primed_d;
        end
    end

    assign bus.mismatch      = mismatch_s;
    assign bus.prop          = ~(|mismatch_s);
    assign bus.err_sticky    = err_sticky_q;
    assign bus.err_count     = err_count_q;
    assign bus.first_err_ch  = first_err_ch_q;
    assign bus.first_err_cyc = first_err_cyc_q;
    assign bus.primed        = primed_q;

endmodule

// File: tb/tb_eq_delay_checker.sv
// -----------------------------------------------------------------------------
// tb_eq_delay_checker
//   Three checker instances share one stimulus stream (2 channels, 8-bit):
//     A: MODE=1, DELAY=3, COUNT_W=8
//     B: MODE=0, DELAY=3, COUNT_W=8
//     C: MODE=1, DELAY=5, COUNT_W=4
//   A reference model keeps the history of reference samples since the last
//   reset. It derives every output from "the sample DELAY clocks ago" and
//   from plain saturating integers. Directed scenarios pin known values, and
//   a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_eq_delay_checker;

    localparam int P_D  [3] = '{3, 3, 5};
    localparam int P_M  [3] = '{1, 0, 1};
    localparam int P_CW [3] = '{8, 8, 4};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        chk_en = 1'b0;
    logic [1:0]  ref_valid = 2'b00;
    logic [15:0] ref_data = 16'h0000;
    logic [15:0] dut_data = 16'h0000;
    logic [7:0]  cmp_mask = 8'hFF;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    eq_delay_checker_if #(.WIDTH(8), .CHANNELS(2), .COUNT_W(8)) if_a ();
    eq_delay_checker_if #(.WIDTH(8), .CHANNELS(2), .COUNT_W(8)) if_b ();
    eq_delay_checker_if #(.WIDTH(8), .CHANNELS(2), .COUNT_W(4)) if_c ();

    assign if_a.chk_en = chk_en;  assign if_a.ref_valid = ref_valid;
    assign if_a.ref_data = ref_data;  assign if_a.dut_data = dut_data;
    assign if_a.cmp_mask = cmp_mask;
    assign if_b.chk_en = chk_en;  assign if_b.ref_valid = ref_valid;
    assign if_b.ref_data = ref_data;  assign if_b.dut_data = dut_data;
    assign if_b.cmp_mask = cmp_mask;
    assign if_c.chk_en = chk_en;  assign if_c.ref_valid = ref_valid;
    assign if_c.ref_data = ref_data;  assign if_c.dut_data = dut_data;
    assign if_c.cmp_mask = cmp_mask;

    eq_delay_checker #(.WIDTH(8), .DELAY(3), .CHANNELS(2), .MODE(1), .COUNT_W(8))
        u_a (.clk(clk), .reset(reset), .bus(if_a.slave));
    eq_delay_checker #(.WIDTH(8), .DELAY(3), .CHANNELS(2), .MODE(0), .COUNT_W(8))
        u_b (.clk(clk), .reset(reset), .bus(if_b.slave));
    eq_delay_checker #(.WIDTH(8), .DELAY(5), .CHANNELS(2), .MODE(1), .COUNT_W(4))
        u_c (.clk(clk), .reset(reset), .bus(if_c.slave));

    // ---------------- reference model ----------------
    int         n_since = 0;          // non-reset clocks since last reset
    logic [1:0] hv [64];
    logic [7:0] hd [64][2];
    int         m_cnt [3];
    int         m_stamp [3];
    int         m_fch [3];
    int         m_fcyc [3];
    int         m_sticky [3];

    task automatic check(input string nm, input int k,
                         input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst=%0d got=%0h expected=%0h t=%0t", nm, k, act, exp, $time);
        end
    endtask

    // Expected mismatch vector for instance k under the current inputs.
    function automatic logic [1:0] model_mm(input int k);
        logic [1:0] r;
        logic       tv;
        logic [7:0] td;
        logic [7:0] dv;
        r = 2'b00;
        if (!reset) begin
            for (int ch = 0; ch < 2; ch++) begin
                if (n_since >= P_D[k]) begin
                    tv = hv[(n_since - P_D[k]) % 64][ch];
                    td = hd[(n_since - P_D[k]) % 64][ch];
                end else begin
                    tv = 1'b0;
                    td = 8'h00;
                end
                dv = dut_data[ch*8 +: 8];
                if (chk_en && (P_M[k] == 0 || tv) && (((td ^ dv) & cmp_mask) != 8'h00))
                    r[ch] = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic model_step();
        logic [1:0] mm;
        int mx;
        if (reset) begin
            n_since = 0;
            for (int k = 0; k < 3; k++) begin
                m_cnt[k] = 0; m_stamp[k] = 0; m_fch[k] = 0; m_fcyc[k] = 0; m_sticky[k] = 0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                mm = model_mm(k);
                mx = (1 << P_CW[k]) - 1;
                if (mm != 2'b00) begin
                    if (m_cnt[k] < mx) m_cnt[k]++;
                    if (m_sticky[k] == 0) begin
                        m_sticky[k] = 1;
                        m_fch[k]    = mm[0] ? 0 : 1;
                        m_fcyc[k]   = m_stamp[k];
                    end
                end
                if (m_stamp[k] < mx) m_stamp[k]++;
            end
            hv[n_since % 64]    = ref_valid;
            hd[n_since % 64][0] = ref_data[7:0];
            hd[n_since % 64][1] = ref_data[15:8];
            n_since++;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Per-cycle comparison of every instance against the model.
    initial begin
        logic [1:0]  o_mm;
        logic        o_prop, o_st, o_pr;
        logic [31:0] o_cnt, o_fcyc, o_fch;
        logic [1:0]  e_mm;
        @(posedge clk);
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                case (k)
                    0: begin
                        o_mm = if_a.mismatch; o_prop = if_a.prop; o_st = if_a.err_sticky;
                        o_pr = if_a.primed; o_cnt = 32'(if_a.err_count);
                        o_fcyc = 32'(if_a.first_err_cyc); o_fch = 32'(if_a.first_err_ch);
                    end
                    1: begin
                        o_mm = if_b.mismatch; o_prop = if_b.prop; o_st = if_b.err_sticky;
                        o_pr = if_b.primed; o_cnt = 32'(if_b.err_count);
                        o_fcyc = 32'(if_b.first_err_cyc); o_fch = 32'(if_b.first_err_ch);
                    end
                    default: begin
                        o_mm = if_c.mismatch; o_prop = if_c.prop; o_st = if_c.err_sticky;
                        o_pr = if_c.primed; o_cnt = 32'(if_c.err_count);
                        o_fcyc = 32'(if_c.first_err_cyc); o_fch = 32'(if_c.first_err_ch);
                    end
                endcase
                e_mm = model_mm(k);
                check("mismatch", k, 32'(o_mm), 32'(e_mm));
                check("prop", k, 32'(o_prop), 32'(e_mm == 2'b00));
                check("err_sticky", k, 32'(o_st), 32'(m_sticky[k]));
                check("err_count", k, o_cnt, 32'(m_cnt[k]));
                check("first_err_ch", k, o_fch, 32'(m_fch[k]));
                check("first_err_cyc", k, o_fcyc, 32'(m_fcyc[k]));
                check("primed", k, 32'(o_pr), 32'(n_since >= P_D[k]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic r, input logic [1:0] v,
                       input logic [7:0] r0, input logic [7:0] r1,
                       input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] m);
        @(posedge clk);
        #1;
        reset     = r;
        ref_valid = v;
        ref_data  = {r1, r0};
        dut_data  = {d1, d0};
        cmp_mask  = m;
    endtask

    initial begin
        logic [7:0] ring [3][2];
        logic [7:0] rd [2];
        logic [7:0] dd [2];
        logic [7:0] mk;

        chk_en = 1'b1;
        // Scenario 1: clean aligned stream.
        cyc(1'b1, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF);
        cyc(1'b1, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF);
        cyc(1'b0, 2'b11, 8'h05, 8'h05, 8'h00, 8'h00, 8'hFF);
        cyc(1'b0, 2'b11, 8'h06, 8'h06, 8'h00, 8'h00, 8'hFF);
        cyc(1'b0, 2'b11, 8'h07, 8'h07, 8'h00, 8'h00, 8'hFF);
        @(negedge clk); check("lit_primed_c2", 0, 32'(if_a.primed), 32'd0);
        cyc(1'b0, 2'b00, 8'h00, 8'h00, 8'h05, 8'h05, 8'hFF);
        @(negedge clk); check("lit_primed_c3", 0, 32'(if_a.primed), 32'd1);
        check("lit_prop_c3", 0, 32'(if_a.prop), 32'd1);
        cyc(1'b0, 2'b00, 8'h00, 8'h00, 8'h06, 8'h06, 8'hFF);
        cyc(1'b0, 2'b00, 8'h00, 8'h00, 8'h07, 8'h07, 8'hFF);
        cyc(1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF);
        @(negedge clk); check("lit_clean_count", 0, 32'(if_a.err_count), 32'd0);
        check("lit_clean_sticky", 1, 32'(if_b.err_sticky), 32'd0);

        // Scenario 2: single corrupted sample at cycle 4 on channel 0.
        cyc(1'b1, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF);
        cyc(1'b0, 2'b11, 8'h05, 8'h05, 8'h00, 8'h00, 8'hFF);
        cyc(1'b0, 2'b11, 8'h06, 8'h06, 8'h00, 8'h00, 8'hFF);
        cyc(1'b0, 2'b11, 8'h07, 8'h07, 8'h00, 8'h00, 8'hFF);
        cyc(1'b0, 2'b00, 8'h00, 8'h00, 8'h05, 8'h05, 8'hFF);
        cyc(1'b0, 2'b00, 8'h00, 8'h00, 8'h08, 8'h06, 8'hFF);
        @(negedge clk); check("lit_mm_c4", 0, 32'(if_a.mismatch), 32'd1);
        cyc(1'b0, 2'b00, 8'h00, 8'h00, 8'h07, 8'h07, 8'hFF);
        @(negedge clk); check("lit_mm_c5", 0, 32'(if_a.mismatch), 32'd0);
        check("lit_sticky", 0, 32'(if_a.err_sticky), 32'd1);
        check("lit_count1", 0, 32'(if_a.err_count), 32'd1);
        check("lit_fcyc4", 0, 32'(if_a.first_err_cyc), 32'd4);

        // Scenario 3: both channels fail at cycle 6, channel 1 alone at 8.
        cyc(1'b1, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF);
        for (int c = 0; c < 10; c++) begin
            rd[0] = 8'h00; dd[0] = 8'h00; dd[1] = 8'h00;
            if (c == 3 || c == 5) rd[0] = 8'h11;
            if (c == 6) begin dd[0] = 8'h22; dd[1] = 8'h22; end
            if (c == 8) begin dd[0] = 8'h11; dd[1] = 8'h33; end
            cyc(1'b0, (rd[0] != 8'h00) ? 2'b11 : 2'b00, rd[0], rd[0], dd[0], dd[1], 8'hFF);
            if (c == 6) begin
                @(negedge clk); check("lit_mm_both", 0, 32'(if_a.mismatch), 32'd3);
            end
        end
        @(negedge clk); check("lit_fch0", 0, 32'(if_a.first_err_ch), 32'd0);
        check("lit_count2", 0, 32'(if_a.err_count), 32'd2);
        check("lit_fcyc6", 0, 32'(if_a.first_err_cyc), 32'd6);

        // Scenario 4: compare mask.
        cyc(1'b1, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF);
        cyc(1'b0, 2'b11, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'hFF);
        cyc(1'b0, 2'b11, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'hFF);
        cyc(1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF);
        cyc(1'b0, 2'b00, 8'h00, 8'h00, 8'h55, 8'h55, 8'h0F);
        @(negedge clk); check("lit_mask_lo", 0, 32'(if_a.mismatch), 32'd0);
        cyc(1'b0, 2'b00, 8'h00, 8'h00, 8'h55, 8'h55, 8'hF0);
        @(negedge clk); check("lit_mask_hi", 0, 32'(if_a.mismatch), 32'd3);

        // Scenario 5: legacy zero-initialised warm-up.
        cyc(1'b1, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF);
        cyc(1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF);
        cyc(1'b0, 2'b00, 8'h00, 8'h00, 8'h01, 8'h01, 8'hFF);
        @(negedge clk); check("lit_mode0_warm", 1, 32'(if_b.mismatch), 32'd3);
        check("lit_mode1_warm", 0, 32'(if_a.mismatch), 32'd0);

        // Scenario 6: saturation on the 4-bit counter, then reset mid-stream.
        cyc(1'b1, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF);
        for (int c = 0; c < 25; c++)
            cyc(1'b0, 2'b11, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF);
        cyc(1'b1, 2'b11, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF);
        @(negedge clk); check("lit_sat15", 2, 32'(if_c.err_count), 32'd15);
        check("lit_sat_fcyc", 2, 32'(if_c.first_err_cyc), 32'd5);
        check("lit_rst_prop", 0, 32'(if_a.prop), 32'd1);
        for (int c = 0; c < 5; c++) begin
            cyc(1'b0, 2'b00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF);
            @(negedge clk);
            if (c == 0) begin
                check("lit_rst_cnt_a", 0, 32'(if_a.err_count), 32'd0);
                check("lit_rst_cnt_c", 2, 32'(if_c.err_count), 32'd0);
                check("lit_rst_sticky_b", 1, 32'(if_b.err_sticky), 32'd0);
                check("lit_rst_primed_a", 0, 32'(if_a.primed), 32'd0);
            end
            if (c < 3) check("lit_flush_a", 0, 32'(if_a.mismatch), 32'd0);
            check("lit_flush_c", 2, 32'(if_c.mismatch), 32'd0);
        end

        // Randomized phase: mostly-correct DUT copy with occasional faults.
        for (int i = 0; i < 3; i++) begin
            ring[i][0] = 8'h00;
            ring[i][1] = 8'h00;
        end
        for (int c = 0; c < 2000; c++) begin
            chk_en = ($urandom_range(0, 15) != 0);
            case ($urandom_range(0, 9))
                0:       mk = 8'h00;
                1, 2, 3: mk = 8'($urandom);
                default: mk = 8'hFF;
            endcase
            for (int ch = 0; ch < 2; ch++) begin
                rd[ch] = 8'($urandom);
                if ($urandom_range(0, 9) < 8) dd[ch] = ring[2][ch];
                else dd[ch] = 8'($urandom);
                if ($urandom_range(0, 9) == 0) dd[ch][$urandom_range(0, 7)] ^= 1'b1;
                ring[2][ch] = ring[1][ch];
                ring[1][ch] = ring[0][ch];
                ring[0][ch] = rd[ch];
            end
            cyc(($urandom_range(0, 299) == 0), 2'($urandom), rd[0], rd[1], dd[0], dd[1], mk);
        end

        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/eq_delay_checker.md
Name: eq_delay_checker

Overview:
- Parametrised, latency-aligned equivalence checker for spec-vs-impl formal and simulation harnesses.
- Delays each channel's reference (spec) output by DELAY cycles and compares it against the matching DUT (impl) output.
- Drives a combinational `prop` for `assert property`, plus registered sticky-error, mismatch-count and first-failure diagnostics.
- Supports multiple channels, per-bit compare masking and valid-qualified comparison. MODE=0 reproduces the legacy zero-reset unqualified compare.

Parameters:
- WIDTH, 8, data width per channel.
- DELAY, 3, reference pipeline depth in cycles; legal range 1..16.
- CHANNELS, 1, number of independent compare channels; legal range 1..8.
- MODE, 1: 0 = compare every cycle against zero-initialised delay line; 1 = compare only when the delayed reference valid is set.
- COUNT_W, 8, width of the saturating error counter and the cycle stamp.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- chk_en  in  1  global compare enable; 0 suppresses all mismatches.
- ref_valid  in  CHANNELS  per-channel reference valid (ignored when MODE=0).
- ref_data  in  CHANNELS*WIDTH  reference outputs, channel i at bits [i*WIDTH +: WIDTH].
- dut_data  in  CHANNELS*WIDTH  DUT outputs, same packing as ref_data.
- cmp_mask  in  WIDTH  per-bit compare mask, shared by all channels; 1 = bit is compared.
- mismatch  out  CHANNELS  combinational per-channel mismatch for the current cycle.
- prop  out  1  combinational; equals ~|mismatch.
- err_sticky  out  1  registered; set on the first mismatch, held until reset.
- err_count  out  COUNT_W  registered, saturating count of cycles with |mismatch.
- first_err_ch  out  3  registered; lowest-index mismatching channel in the first failing cycle.
- first_err_cyc  out  COUNT_W  registered; cycle stamp of the first failing cycle.
- primed  out  1  registered; 1 once DELAY cycles have elapsed since reset.

Behaviour:
- Delay line: per channel, DELAY stages of {valid, data}.
  - Stage 0 captures ref_valid/ref_data each clock. Stage k captures stage k-1.
  - Tap = stage DELAY-1, i.e. the reference value sampled DELAY clocks earlier.
- Reset (synchronous): all stage data and valids are 0. err_sticky=0, err_count=0, first_err_ch=0, first_err_cyc=0, primed=0, internal cycle counter=0.
  - Reset asserted mid-run discards all in-flight stages; nothing issued before reset is ever compared.
- Reset cycle: while reset=1, mismatch=0 and prop=1, regardless of inputs.
- Compare for channel i (combinational):
  - m_i = chk_en & q_i & |((tap_data_i ^ dut_i) & cmp_mask).
  - q_i = 1 when MODE=0; q_i = tap_valid_i when MODE=1.
- MODE=0 warm-up: during the first DELAY cycles after reset the tap holds 0. The DUT must output 0 during this window or a mismatch is flagged. This is intended legacy behaviour.
- MODE=1 warm-up: no check fires until a valid reference reaches the tap.
- cmp_mask = 0: every channel always matches.
- Cycle counter: increments each non-reset clock and saturates at 2^COUNT_W-1.
- primed: set on the clock where the cycle counter reaches DELAY.
- On each clock with |mismatch and reset=0:
  - err_count increments, saturating at all-ones.
  - If err_sticky=0, err_sticky is set; first_err_ch and first_err_cyc are loaded.
  - Once err_sticky=1, first_err_ch and first_err_cyc are frozen.
- first_err_ch: priority-encoded lowest index among simultaneous mismatching channels.
- first_err_cyc: cycle-counter value before increment in the failing cycle. The first clock after reset is cycle 0.
- Registered outputs update one clock after the mismatching cycle; prop and mismatch have zero latency.
- Parameter legality: out-of-range DELAY or CHANNELS is an elaboration error (generate-time check).

Test Plan:
- MODE=1, DELAY=3, CHANNELS=1: ref_data 5,6,7 valid at cycles 0..2; dut_data 5,6,7 at cycles 3..5 -> prop=1 throughout, err_count=0, primed=1 from cycle 3.
- Same setup, dut_data=8 at cycle 4 -> mismatch[0]=1 at cycle 4 only; after cycle 4: err_sticky=1, err_count=1, first_err_cyc=4.
- CHANNELS=2: channels 0 and 1 both mismatch at cycle 6 -> first_err_ch=0. A later channel-1-only mismatch leaves first_err_ch=0 and err_count=2.
- cmp_mask=8'h0F, tap=8'hA5, dut=8'h55 -> match. cmp_mask=8'hF0 with the same data -> mismatch.
- MODE=0, DUT drives 8'h01 at cycle 1 after reset -> mismatch (tap=0). MODE=1 with the same stimulus -> no mismatch.
- COUNT_W=4, 20 consecutive mismatch cycles -> err_count holds at 15. Assert reset mid-stream -> all outputs 0 next clock, and pre-reset in-flight data is never compared.
